// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search control path: phase select
// codes driven to the RAM controller, the key sequencer state encoding and
// the accepted plaintext character range.
package rc4_pkg;

    // One-hot phase select driven on the controller's mode input
    localparam logic [2:0] MODE_IDLE = 3'b000;
    localparam logic [2:0] MODE_INIT = 3'b001;
    localparam logic [2:0] MODE_SHUF = 3'b010;
    localparam logic [2:0] MODE_DECR = 3'b100;

    // Plaintext is accepted only if every byte is 'a'..'z' or a space
    localparam int unsigned CHAR_LO    = 97;
    localparam int unsigned CHAR_HI    = 122;
    localparam int unsigned CHAR_SPACE = 32;

    typedef enum logic [3:0] {
        KS_IDLE,
        KS_INIT,
        KS_GAP0,
        KS_SHUF,
        KS_GAP1,
        KS_DECR,
        KS_GAP2,
        KS_CK_ADDR,
        KS_CK_CMP,
        KS_NEXT_KEY,
        KS_FOUND,
        KS_FAIL
    } keyseq_state_t;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext filter: flags a byte as acceptable when it is a
// lowercase ASCII letter or a space. Kept separate so parallel searchers
// can instantiate one per lane.
module rc4_char_check #(
    parameter int RAM_WIDTH = 8
) (
    input  logic [RAM_WIDTH-1:0] i_byte,
    output logic                 o_valid
);
    import rc4_pkg::*;

    logic [31:0] w_val;

    assign w_val   = 32'(i_byte);
    assign o_valid = ((w_val >= CHAR_LO) && (w_val <= CHAR_HI)) || (w_val == CHAR_SPACE);

endmodule

// File: rtl/rc4_key_sequencer.sv
// RC4 key search sequencer. For each candidate key it runs the controller
// through S-box init, key shuffle and decrypt (one-hot mode select, one idle
// gap cycle between phases), then reads the decrypted message back and
// accepts the key only if every byte is lowercase ASCII or space.
//
// Build option KEYSEQ_CHECK_EN:
//   defined   - full search: message check, key stepping, FOUND or FAIL.
//   undefined - single-key decrypt: after the last gap go straight to FOUND;
//               the read address is tied to 0 and fail is never raised.
module rc4_key_sequencer #(
    parameter int RAM_WIDTH          = 8,
    parameter int KEY_LENGTH         = 3,
    parameter int KEY_BITS           = 22,
    parameter int MESSAGE_LENGTH     = 32,
    parameter int MESSAGE_LOG_LENGTH = 5,
    parameter int NUM_DEVICES        = 3
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [KEY_BITS-1:0]                   key_start,
    input  logic [NUM_DEVICES-1:0]                finish_bus,
    output logic [2:0]                            mode,
    output logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0]  key,
    output logic [MESSAGE_LOG_LENGTH-1:0]         aRdAddr,
    input  logic [RAM_WIDTH-1:0]                  aOut,
    output logic                                  busy,
    output logic                                  found,
    output logic                                  fail
);
    import rc4_pkg::*;

    keyseq_state_t                       r_state;
    keyseq_state_t                       w_state_nxt;
    logic [KEY_BITS-1:0]                 r_key;
    logic                                w_load_key;
    logic                                w_inc_key;
    logic [KEY_LENGTH*RAM_WIDTH-1:0]     w_key_ext;

`ifdef KEYSEQ_CHECK_EN
    localparam logic [MESSAGE_LOG_LENGTH-1:0] IDX_LAST = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);

    logic [MESSAGE_LOG_LENGTH-1:0]       r_idx;
    logic                                w_idx_clr;
    logic                                w_idx_inc;
    logic                                w_byte_ok;

    rc4_char_check #(
        .RAM_WIDTH (RAM_WIDTH)
    ) u_char_check (
        .i_byte  (aOut),
        .o_valid (w_byte_ok)
    );
`else
    // Read data is not inspected in the single-key build
    logic w_unused_aout;
    assign w_unused_aout = ^aOut;
`endif

    // Next-state and key/index control; start is honoured only while parked
    always_comb begin
        w_state_nxt = r_state;
        w_load_key  = 1'b0;
        w_inc_key   = 1'b0;
`ifdef KEYSEQ_CHECK_EN
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
`endif
        case (r_state)
            KS_IDLE, KS_FOUND, KS_FAIL: begin
                if (start) begin
                    w_state_nxt = KS_INIT;
                    w_load_key  = 1'b1;
`ifdef KEYSEQ_CHECK_EN
                    w_idx_clr   = 1'b1;
`endif
                end
            end
            KS_INIT: if (finish_bus[0]) w_state_nxt = KS_GAP0;
            KS_GAP0: w_state_nxt = KS_SHUF;
            KS_SHUF: if (finish_bus[1]) w_state_nxt = KS_GAP1;
            KS_GAP1: w_state_nxt = KS_DECR;
            KS_DECR: if (finish_bus[2]) w_state_nxt = KS_GAP2;
`ifdef KEYSEQ_CHECK_EN
            KS_GAP2:    w_state_nxt = KS_CK_ADDR;
            KS_CK_ADDR: w_state_nxt = KS_CK_CMP;
            KS_CK_CMP: begin
                if (!w_byte_ok) begin
                    w_state_nxt = KS_NEXT_KEY;
                end else if (r_idx == IDX_LAST) begin
                    w_state_nxt = KS_FOUND;
                end else begin
                    w_state_nxt = KS_CK_ADDR;
                    w_idx_inc   = 1'b1;
                end
            end
            KS_NEXT_KEY: begin
                // Top of the key space is terminal; the counter never wraps
                if (&r_key) begin
                    w_state_nxt = KS_FAIL;
                end else begin
                    w_state_nxt = KS_INIT;
                    w_inc_key   = 1'b1;
                    w_idx_clr   = 1'b1;
                end
            end
`else
            KS_GAP2: w_state_nxt = KS_FOUND;
`endif
            default: w_state_nxt = KS_IDLE;
        endcase
    end

    // Phase select is a pure function of state so reset forces 000 at once
    always_comb begin
        mode = MODE_IDLE;
        case (r_state)
            KS_INIT: mode = MODE_INIT;
            KS_SHUF: mode = MODE_SHUF;
            KS_DECR: mode = MODE_DECR;
            default: mode = MODE_IDLE;
        endcase
    end

    // Zero-extend the search counter onto the controller key bytes
    always_comb begin
        w_key_ext                 = '0;
        w_key_ext[KEY_BITS-1:0]   = r_key;
    end

    assign key   = w_key_ext;
    assign busy  = (r_state != KS_IDLE) && (r_state != KS_FOUND) && (r_state != KS_FAIL);
    assign found = (r_state == KS_FOUND);

`ifdef KEYSEQ_CHECK_EN
    assign fail    = (r_state == KS_FAIL);
    assign aRdAddr = r_idx;
`else
    assign fail    = 1'b0;
    assign aRdAddr = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= KS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Key counter: loaded on accepted start, stepped only on NEXT_KEY exit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key <= '0;
        end else if (w_load_key) begin
            r_key <= key_start;
        end else if (w_inc_key) begin
            r_key <= r_key + KEY_BITS'(1);
        end
    end

`ifdef KEYSEQ_CHECK_EN
    // Message byte index, held across the address/compare pair
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
        end else if (w_idx_clr) begin
            r_idx <= '0;
        end else if (w_idx_inc) begin
            r_idx <= r_idx + MESSAGE_LOG_LENGTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rc4_key_sequencer.sv
// Testbench for rc4_key_sequencer. Device models raise their finish level
// 5/7/9 cycles into their phase; the message RAM has a one-cycle read.
// Expectations for the check build are selected by KEYSEQ_CHECK_EN.
module tb_rc4_key_sequencer;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [21:0]       key_start;
    logic [2:0]        finish_bus;
    logic [2:0]        mode;
    logic [2:0][7:0]   key;
    logic [4:0]        aRdAddr;
    logic [7:0]        aOut = 8'h00;
    logic              busy;
    logic              found;
    logic              fail;

    int n_vec = 0;
    int n_err = 0;

`ifdef KEYSEQ_CHECK_EN
    localparam int EXP_ZERO  = 67;   // 3 gaps + 32 bytes * 2
    localparam int EXP_TOTAL = 91;   // 6 + 8 + 10 + 67
`else
    localparam int EXP_ZERO  = 3;
    localparam int EXP_TOTAL = 27;
`endif

    rc4_key_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_start  (key_start),
        .finish_bus (finish_bus),
        .mode       (mode),
        .key        (key),
        .aRdAddr    (aRdAddr),
        .aOut       (aOut),
        .busy       (busy),
        .found      (found),
        .fail       (fail)
    );

    always #5 clk = ~clk;

    // Device models: finish level rises LAT cycles into the phase, drops when mode clears
    logic [2:0] fin_model = 3'b000;
    int         cnt [3]   = '{0, 0, 0};
    logic       stray_en  = 1'b0;

    function automatic int lat(input int d);
        case (d)
            0:       return 5;
            1:       return 7;
            default: return 9;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (mode[d]) begin
                fin_model[d] <= (cnt[d] >= lat(d) - 1);
                cnt[d]       <= cnt[d] + 1;
            end else begin
                fin_model[d] <= 1'b0;
                cnt[d]       <= 0;
            end
        end
    end

    // Optionally hold every finish bit that does not belong to the active phase high
    assign finish_bus = fin_model | (stray_en ? ~mode : 3'b000);

    logic [7:0] mem [32];

    always @(posedge clk) aOut <= mem[aRdAddr];

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 32; i++) mem[i] = v;
    endtask

    task automatic do_start(input logic [21:0] k);
        @(negedge clk);
        key_start = k;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(output int c_init, output int c_shuf, output int c_decr,
                             output int c_zero, output int c_total, output bit to);
        c_init = 0; c_shuf = 0; c_decr = 0; c_zero = 0; c_total = 0;
        while (busy && c_total < 2000) begin
            case (mode)
                3'b001:  c_init++;
                3'b010:  c_shuf++;
                3'b100:  c_decr++;
                3'b000:  c_zero++;
                default: ;
            endcase
            c_total++;
            @(negedge clk);
        end
        to = busy;
    endtask

    task automatic wait_reinit(output int c_zero, output int c_total, output bit to);
        bit left;
        left = 1'b0; c_zero = 0; c_total = 0;
        while (c_total < 2000) begin
            if (mode == 3'b001 && left) break;
            if (mode != 3'b001) left = 1'b1;
            if (mode == 3'b000) c_zero++;
            c_total++;
            @(negedge clk);
        end
        to = (c_total >= 2000);
    endtask

    task automatic wait_mode(input logic [2:0] m, output bit to);
        int c;
        c = 0;
        while (mode !== m && c < 500) begin
            @(negedge clk);
            c++;
        end
        to = (mode !== m);
    endtask

    task automatic test_reset;
        int ci, cs, cd, cz, ct;
        bit to;
        fill_mem(8'h61);
        reset = 1'b0; start = 1'b1; key_start = 22'h000123;
        repeat (3) @(negedge clk);
        n_vec++; if (mode !== 3'b000) begin n_err++; $display("FAIL reset_mode: got %b want 000", mode); end
        n_vec++; if (key !== 24'h0) begin n_err++; $display("FAIL reset_key: got %h want 000000", key); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (found !== 1'b0 || fail !== 1'b0) begin n_err++; $display("FAIL reset_status: got found=%b fail=%b want 0 0", found, fail); end
        n_vec++; if (aRdAddr !== 5'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", aRdAddr); end
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        n_vec++; if (mode !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL idle_hold: got mode=%b busy=%b want 000 0", mode, busy); end
        do_start(22'h000123);
        n_vec++; if (mode !== 3'b001) begin n_err++; $display("FAIL start_mode: got %b want 001", mode); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy: got %b want 1", busy); end
        n_vec++; if (key !== 24'h000123) begin n_err++; $display("FAIL start_key: got %h want 000123", key); end
        wait_done(ci, cs, cd, cz, ct, to);
        n_vec++; if (to) begin n_err++; $display("FAIL first_run_timeout: busy still %b want 0", busy); end
    endtask

    task automatic test_found;
        int ci, cs, cd, cz, ct;
        bit to;
        fill_mem(8'h61);
        stray_en = 1'b1;
        do_start(22'h000123);
        wait_done(ci, cs, cd, cz, ct, to);
        stray_en = 1'b0;
        n_vec++; if (to) begin n_err++; $display("FAIL found_timeout: busy still %b want 0", busy); end
        n_vec++; if (ci !== 6) begin n_err++; $display("FAIL init_cycles: got %0d want 6", ci); end
        n_vec++; if (cs !== 8) begin n_err++; $display("FAIL shuf_cycles: got %0d want 8", cs); end
        n_vec++; if (cd !== 10) begin n_err++; $display("FAIL decr_cycles: got %0d want 10", cd); end
        n_vec++; if (cz !== EXP_ZERO) begin n_err++; $display("FAIL idle_mode_cycles: got %0d want %0d", cz, EXP_ZERO); end
        n_vec++; if (ct !== EXP_TOTAL) begin n_err++; $display("FAIL busy_cycles: got %0d want %0d", ct, EXP_TOTAL); end
        n_vec++; if (found !== 1'b1 || fail !== 1'b0) begin n_err++; $display("FAIL found_status: got found=%b fail=%b want 1 0", found, fail); end
        n_vec++; if (key !== 24'h000123) begin n_err++; $display("FAIL found_key: got %h want 000123", key); end
        n_vec++; if (mode !== 3'b000) begin n_err++; $display("FAIL found_mode: got %b want 000", mode); end
`ifndef KEYSEQ_CHECK_EN
        n_vec++; if (aRdAddr !== 5'd0) begin n_err++; $display("FAIL addr_tied: got %0d want 0", aRdAddr); end
`endif
    endtask

`ifdef KEYSEQ_CHECK_EN
    task automatic test_reject_first;
        int ci, cs, cd, cz, ct;
        bit to;
        fill_mem(8'h61);
        mem[0] = 8'h7B;
        do_start(22'h000123);
        wait_reinit(cz, ct, to);
        n_vec++; if (to) begin n_err++; $display("FAIL rej0_timeout: mode %b want 001", mode); end
        n_vec++; if (ct !== 30) begin n_err++; $display("FAIL rej0_cycles: got %0d want 30", ct); end
        n_vec++; if (cz !== 6) begin n_err++; $display("FAIL rej0_idle_cycles: got %0d want 6", cz); end
        n_vec++; if (key !== 24'h000124) begin n_err++; $display("FAIL rej0_key: got %h want 000124", key); end
        fill_mem(8'h61);
        wait_done(ci, cs, cd, cz, ct, to);
        n_vec++; if (found !== 1'b1 || key !== 24'h000124) begin n_err++; $display("FAIL rej0_then_found: got found=%b key=%h want 1 000124", found, key); end
    endtask

    task automatic test_reject_last;
        int ci, cs, cd, cz, ct;
        bit to;
        fill_mem(8'h61);
        mem[31] = 8'h60;
        do_start(22'h000200);
        wait_reinit(cz, ct, to);
        n_vec++; if (to) begin n_err++; $display("FAIL rej31_timeout: mode %b want 001", mode); end
        n_vec++; if (ct !== 92) begin n_err++; $display("FAIL rej31_cycles: got %0d want 92", ct); end
        n_vec++; if (cz !== 68) begin n_err++; $display("FAIL rej31_idle_cycles: got %0d want 68", cz); end
        n_vec++; if (key !== 24'h000201) begin n_err++; $display("FAIL rej31_key: got %h want 000201", key); end
        fill_mem(8'h61);
        wait_done(ci, cs, cd, cz, ct, to);
        n_vec++; if (found !== 1'b1 || key !== 24'h000201) begin n_err++; $display("FAIL rej31_then_found: got found=%b key=%h want 1 000201", found, key); end
    endtask

    task automatic test_char_bounds;
        logic [7:0] vals [5] = '{8'h20, 8'h7A, 8'h1F, 8'h60, 8'h7B};
        bit         acc  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int ci, cs, cd, cz, ct, cyc;
        bit to, left;
        for (int v = 0; v < 5; v++) begin
            fill_mem(8'h61);
            mem[5] = vals[v];
            do_start(22'h000300);
            cyc = 0; left = 1'b0;
            while (cyc < 2000) begin
                if (!busy) break;
                if (mode == 3'b001 && left) break;
                if (mode != 3'b001) left = 1'b1;
                cyc++;
                @(negedge clk);
            end
            n_vec++; if (found !== acc[v]) begin n_err++; $display("FAIL char_%h: got found=%b want %b", vals[v], found, acc[v]); end
            n_vec++;
            if (key !== (acc[v] ? 24'h000300 : 24'h000301)) begin
                n_err++; $display("FAIL char_%h_key: got %h want %h", vals[v], key, acc[v] ? 24'h000300 : 24'h000301);
            end
            fill_mem(8'h61);
            if (busy) wait_done(ci, cs, cd, cz, ct, to);
        end
    endtask
`endif

    task automatic test_fail_no_wrap;
        int ci, cs, cd, cz, ct;
        bit to;
        fill_mem(8'h61);
        mem[0] = 8'h7B;
        do_start(22'h3FFFFF);
        wait_mode(3'b100, to);
        n_vec++; if (to) begin n_err++; $display("FAIL reach_decr: mode %b want 100", mode); end
        key_start = 22'h000055;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        n_vec++; if (mode !== 3'b100 || key !== 24'h3FFFFF) begin n_err++; $display("FAIL start_in_decr: got mode=%b key=%h want 100 3fffff", mode, key); end
        wait_done(ci, cs, cd, cz, ct, to);
        n_vec++; if (to) begin n_err++; $display("FAIL top_key_timeout: busy still %b want 0", busy); end
`ifdef KEYSEQ_CHECK_EN
        n_vec++; if (fail !== 1'b1 || found !== 1'b0) begin n_err++; $display("FAIL top_key_status: got fail=%b found=%b want 1 0", fail, found); end
`else
        n_vec++; if (fail !== 1'b0 || found !== 1'b1) begin n_err++; $display("FAIL top_key_status: got fail=%b found=%b want 0 1", fail, found); end
`endif
        n_vec++; if (key !== 24'h3FFFFF) begin n_err++; $display("FAIL top_key_value: got %h want 3fffff", key); end
        repeat (4) @(negedge clk);
        n_vec++; if (key !== 24'h3FFFFF || busy !== 1'b0) begin n_err++; $display("FAIL top_key_hold: got key=%h busy=%b want 3fffff 0", key, busy); end
        fill_mem(8'h61);
        do_start(22'h000010);
        n_vec++; if (fail !== 1'b0 || found !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL restart_clear: got fail=%b found=%b busy=%b want 0 0 1", fail, found, busy); end
        wait_done(ci, cs, cd, cz, ct, to);
        n_vec++; if (found !== 1'b1 || key !== 24'h000010) begin n_err++; $display("FAIL restart_found: got found=%b key=%h want 1 000010", found, key); end
    endtask

    task automatic test_reset_mid_run;
        int ci, cs, cd, cz, ct;
        bit to;
        fill_mem(8'h61);
        do_start(22'h000200);
        wait_mode(3'b100, to);
        n_vec++; if (to) begin n_err++; $display("FAIL rst_reach_decr: mode %b want 100", mode); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if (mode !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL async_reset: got mode=%b busy=%b want 000 0", mode, busy); end
        n_vec++; if (key !== 24'h0 || found !== 1'b0) begin n_err++; $display("FAIL async_reset_key: got key=%h found=%b want 000000 0", key, found); end
        @(negedge clk);
        reset = 1'b1;
        do_start(22'h000201);
        wait_done(ci, cs, cd, cz, ct, to);
        n_vec++; if (ct !== EXP_TOTAL) begin n_err++; $display("FAIL rerun_cycles: got %0d want %0d", ct, EXP_TOTAL); end
        n_vec++; if (found !== 1'b1 || key !== 24'h000201) begin n_err++; $display("FAIL rerun_found: got found=%b key=%h want 1 000201", found, key); end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        key_start = '0;
        test_reset;
        test_found;
`ifdef KEYSEQ_CHECK_EN
        test_reject_first;
        test_reject_last;
        test_char_bounds;
`endif
        test_fail_no_wrap;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
